// File: rtl/cmd_assembler_if.sv
// cmd_assembler_if: FIFO read port and ALU command handshake seen by cmd_assembler.
interface cmd_assembler_if;
    logic       fifo_empty;
    logic [7:0] fifo_rdd;
    logic       fifo_rde;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       sync_err;
    logic       timeout_err;
    logic [7:0] frame_cnt;
    modport master (
        input  fifo_empty, fifo_rdd, cmd_ready,
        output fifo_rde, cmd_valid, cmd_op, cmd_a, cmd_b, sync_err, timeout_err, frame_cnt
    );
    modport slave (
        output fifo_empty, fifo_rdd, cmd_ready,
        input  fifo_rde, cmd_valid, cmd_op, cmd_a, cmd_b, sync_err, timeout_err, frame_cnt
    );
endinterface

// File: rtl/cmd_assembler.sv
// cmd_assembler: pops bytes from a FIFO and presents {header, A, B} frames on a valid/ready handshake.
module cmd_assembler #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic            clk_w,
    input logic            reset,
    cmd_assembler_if.master bus
);
    localparam logic [7:0] TO = 8'(TIMEOUT);
    typedef enum logic [1:0] {S_HDR, S_A, S_B, S_OUT} state_t;
    state_t     state, state_nx;
    logic       rd_pend;
    logic [7:0] tcnt;
    logic       cap, hdr_ok, expire, accept;
    // a byte is on fifo_rdd exactly in the cycle after a read was issued
    assign cap          = rd_pend;
    assign hdr_ok       = bus.fifo_rdd[7:4] == 4'hA;
    assign expire       = (state == S_A || state == S_B) && !cap && tcnt == TO;
    assign accept       = state == S_OUT && bus.cmd_ready;
    assign bus.fifo_rde = state != S_OUT && !bus.fifo_empty && !rd_pend;
    assign bus.cmd_valid = state == S_OUT;
    always_comb begin
        state_nx = state;
        case (state)
            S_HDR:   state_nx = cap && hdr_ok ? S_A : S_HDR;
            S_A:     state_nx = cap ? S_B : expire ? S_HDR : S_A;
            S_B:     state_nx = cap ? S_OUT : expire ? S_HDR : S_B;
            default: state_nx = accept ? S_HDR : S_OUT;
        endcase
    end
    always_ff @(posedge clk_w or posedge reset) begin
        if (reset) begin
            state           <= S_HDR;
            rd_pend         <= 1'b0;
            tcnt            <= 8'd0;
            bus.cmd_op      <= 4'd0;
            bus.cmd_a       <= 8'd0;
            bus.cmd_b       <= 8'd0;
            bus.sync_err    <= 1'b0;
            bus.timeout_err <= 1'b0;
            bus.frame_cnt   <= 8'd0;
        end else begin
            state           <= state_nx;
            rd_pend         <= bus.fifo_rde;
            tcnt            <= (cap || expire || state == S_HDR || state == S_OUT) ? 8'd0 : tcnt + 8'd1;
            bus.sync_err    <= state == S_HDR && cap && !hdr_ok;
            bus.timeout_err <= expire;
            if (cap && state == S_HDR && hdr_ok) bus.cmd_op <= bus.fifo_rdd[3:0];
            if (cap && state == S_A) bus.cmd_a <= bus.fifo_rdd;
            if (cap && state == S_B) bus.cmd_b <= bus.fifo_rdd;
            if (accept) bus.frame_cnt <= bus.frame_cnt + 8'd1;
        end
    end
endmodule
